// File: rtl/alu_result_checker.sv
// alu_result_checker
//   Result-side scoreboard for the 4-bit ALU. It takes one transaction per cycle,
//   recomputes the golden result one cycle later (stage 1), and keeps saturating
//   pass/fail/illegal counters. The first mismatch is captured for debug. When
//   HALT_ON_FAIL is set, intake stops after a failing compare until clear or reset.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   clear                 synchronous clear of counters/capture/FSM, drops stage 1
//   in_valid / in_ready   transaction handshake (in_ready = FSM in RUN)
//   operand_a/b, operation, dut_result, dut_zero   transaction under check
//   chk_valid, chk_fail   one-cycle compare pulse and its mismatch flag
//   pass_cnt, fail_cnt, illegal_cnt               saturating counters
//   halted                FSM in HALT
//   cap_valid, cap_op, cap_a, cap_b, cap_exp, cap_got   first-failure capture
module alu_result_checker #(
  parameter int unsigned CNT_W        = 16,
  parameter bit          HALT_ON_FAIL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operand_a,
  input  logic [3:0]       operand_b,
  input  logic [2:0]       operation,
  input  logic [7:0]       dut_result,
  input  logic             dut_zero,
  output logic             chk_valid,
  output logic             chk_fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             halted,
  output logic             cap_valid,
  output logic [2:0]       cap_op,
  output logic [3:0]       cap_a,
  output logic [3:0]       cap_b,
  output logic [7:0]       cap_exp,
  output logic [7:0]       cap_got
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e r_state, w_state_next;

  // Stage 1: registered transaction awaiting compare
  logic       r_s1_valid;
  logic [3:0] r_s1_a, r_s1_b;
  logic [2:0] r_s1_op;
  logic [7:0] r_s1_res;
  logic       r_s1_zero;

  logic             r_chk_valid, r_chk_fail;
  logic [CNT_W-1:0] r_pass_cnt, r_fail_cnt, r_ill_cnt;
  logic             r_cap_valid;
  logic [2:0]       r_cap_op;
  logic [3:0]       r_cap_a, r_cap_b;
  logic [7:0]       r_cap_exp, r_cap_got;

  logic       w_xfer, w_sync_clr;
  logic [7:0] w_exp;
  logic       w_legal, w_cmp, w_ill, w_fail;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign in_ready   = (r_state == StRun);
  assign w_sync_clr = !rst_n || clear;
  // A transfer coincident with clear is discarded
  assign w_xfer     = in_valid && in_ready && !clear;

  // Golden model: operands zero-extended, results taken mod 256
  always_comb begin
    w_exp   = 8'h00;
    w_legal = 1'b1;
    case (r_s1_op)
      3'b000:  w_exp = {4'h0, r_s1_a} + {4'h0, r_s1_b};
      3'b001:  w_exp = {4'h0, r_s1_a} - {4'h0, r_s1_b};
      3'b010:  w_exp = {4'h0, r_s1_a & r_s1_b};
      3'b011:  w_exp = {4'h0, r_s1_a | r_s1_b};
      3'b100:  w_exp = {4'h0, r_s1_a} * {4'h0, r_s1_b};
      default: w_legal = 1'b0;
    endcase
  end

  assign w_cmp  = r_s1_valid && w_legal;
  assign w_ill  = r_s1_valid && !w_legal;
  assign w_fail = w_cmp && ((r_s1_res != w_exp) || (r_s1_zero != (w_exp == 8'h00)));

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = StRun;
    end else if (r_state == StRun && w_fail && HALT_ON_FAIL) begin
      w_state_next = StHalt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_sync_clr) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= 4'h0;
      r_s1_b     <= 4'h0;
      r_s1_op    <= 3'b000;
      r_s1_res   <= 8'h00;
      r_s1_zero  <= 1'b0;
    end else begin
      r_s1_valid <= w_xfer;
      if (w_xfer) begin
        r_s1_a    <= operand_a;
        r_s1_b    <= operand_b;
        r_s1_op   <= operation;
        r_s1_res  <= dut_result;
        r_s1_zero <= dut_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_sync_clr) begin
      r_chk_valid <= 1'b0;
      r_chk_fail  <= 1'b0;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_ill_cnt   <= '0;
    end else begin
      r_chk_valid <= w_cmp;
      r_chk_fail  <= w_fail;
      if (w_cmp && !w_fail) r_pass_cnt <= sat_inc(r_pass_cnt);
      if (w_fail)           r_fail_cnt <= sat_inc(r_fail_cnt);
      if (w_ill)            r_ill_cnt  <= sat_inc(r_ill_cnt);
    end
  end

  // First-failure capture; later fails leave it untouched
  always_ff @(posedge clk) begin
    if (w_sync_clr) begin
      r_cap_valid <= 1'b0;
      r_cap_op    <= 3'b000;
      r_cap_a     <= 4'h0;
      r_cap_b     <= 4'h0;
      r_cap_exp   <= 8'h00;
      r_cap_got   <= 8'h00;
    end else if (w_fail && !r_cap_valid) begin
      r_cap_valid <= 1'b1;
      r_cap_op    <= r_s1_op;
      r_cap_a     <= r_s1_a;
      r_cap_b     <= r_s1_b;
      r_cap_exp   <= w_exp;
      r_cap_got   <= r_s1_res;
    end
  end

  assign chk_valid   = r_chk_valid;
  assign chk_fail    = r_chk_fail;
  assign pass_cnt    = r_pass_cnt;
  assign fail_cnt    = r_fail_cnt;
  assign illegal_cnt = r_ill_cnt;
  assign halted      = (r_state == StHalt);
  assign cap_valid   = r_cap_valid;
  assign cap_op      = r_cap_op;
  assign cap_a       = r_cap_a;
  assign cap_b       = r_cap_b;
  assign cap_exp     = r_cap_exp;
  assign cap_got     = r_cap_got;

endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench for alu_result_checker (CNT_W=4, HALT_ON_FAIL=1).
module tb_alu_result_checker;

  localparam int unsigned CntW   = 4;
  localparam int          CntMax = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      operand_a = 4'h0;
  logic [3:0]      operand_b = 4'h0;
  logic [2:0]      operation = 3'b000;
  logic [7:0]      dut_result = 8'h00;
  logic            dut_zero = 1'b0;
  logic            chk_valid, chk_fail, halted, cap_valid;
  logic [CntW-1:0] pass_cnt, fail_cnt, illegal_cnt;
  logic [2:0]      cap_op;
  logic [3:0]      cap_a, cap_b;
  logic [7:0]      cap_exp, cap_got;

  always #5 clk = ~clk;

  alu_result_checker #(
    .CNT_W       (CntW),
    .HALT_ON_FAIL(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .operation  (operation),
    .dut_result (dut_result),
    .dut_zero   (dut_zero),
    .chk_valid  (chk_valid),
    .chk_fail   (chk_fail),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .illegal_cnt(illegal_cnt),
    .halted     (halted),
    .cap_valid  (cap_valid),
    .cap_op     (cap_op),
    .cap_a      (cap_a),
    .cap_b      (cap_b),
    .cap_exp    (cap_exp),
    .cap_got    (cap_got)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic       z;
  } item_t;

  item_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  string phase = "init";

  // Reference state
  int         m_pass, m_fail, m_ill;
  bit         m_halt, m_cap_v;
  logic [2:0] m_cap_op;
  logic [3:0] m_cap_a, m_cap_b;
  logic [7:0] m_cap_exp, m_cap_got;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL [%s] %s: got 0x%0h expected 0x%0h", phase, tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CntMax) ? CntMax : v + 1;
  endfunction

  // Returns -1 for illegal opcodes, else the 8-bit expected result
  function automatic int gold(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int ia = int'(a);
    int ib = int'(b);
    case (op)
      3'd0:    return (ia + ib) % 256;
      3'd1:    return (ia - ib + 256) % 256;
      3'd2:    return int'(a & b);
      3'd3:    return int'(a | b);
      3'd4:    return (ia * ib) % 256;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    sb.delete();
    m_pass = 0; m_fail = 0; m_ill = 0;
    m_halt = 1'b0; m_cap_v = 1'b0;
    m_cap_op = 3'b000; m_cap_a = 4'h0; m_cap_b = 4'h0;
    m_cap_exp = 8'h00; m_cap_got = 8'h00;
  endtask

  task automatic check_state();
    check_eq("pass_cnt", 32'(pass_cnt), 32'(m_pass));
    check_eq("fail_cnt", 32'(fail_cnt), 32'(m_fail));
    check_eq("illegal_cnt", 32'(illegal_cnt), 32'(m_ill));
    check_eq("halted", 32'(halted), 32'(m_halt));
    check_eq("in_ready", 32'(in_ready), 32'(!m_halt));
    check_eq("cap_valid", 32'(cap_valid), 32'(m_cap_v));
    check_eq("cap_op", 32'(cap_op), 32'(m_cap_op));
    check_eq("cap_a", 32'(cap_a), 32'(m_cap_a));
    check_eq("cap_b", 32'(cap_b), 32'(m_cap_b));
    check_eq("cap_exp", 32'(cap_exp), 32'(m_cap_exp));
    check_eq("cap_got", 32'(cap_got), 32'(m_cap_got));
  endtask

  task automatic score(input item_t it);
    int         e;
    logic [7:0] e8;
    bit         f;
    e = gold(it.a, it.b, it.op);
    if (e < 0) begin
      m_ill = sat(m_ill);
      check_eq("chk_valid_illegal", 32'(chk_valid), 32'd0);
    end else begin
      e8 = 8'(e);
      f  = (it.res != e8) || (it.z != (e == 0));
      check_eq("chk_valid", 32'(chk_valid), 32'd1);
      check_eq("chk_fail", 32'(chk_fail), 32'(f));
      if (f) begin
        m_fail = sat(m_fail);
        m_halt = 1'b1;
        if (!m_cap_v) begin
          m_cap_v = 1'b1; m_cap_op = it.op; m_cap_a = it.a; m_cap_b = it.b;
          m_cap_exp = e8; m_cap_got = it.res;
        end
      end else begin
        m_pass = sat(m_pass);
      end
    end
  endtask

  // One clock: drive at negedge, check results of the previous transfer after posedge
  task automatic cycle(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [7:0] res, input logic z);
    bit    acc;
    item_t it;
    @(negedge clk);
    rst_n = 1'b1; clear = 1'b0;
    in_valid = v; operand_a = a; operand_b = b; operation = op;
    dut_result = res; dut_zero = z;
    acc = v && in_ready;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      score(it);
    end else begin
      check_eq("chk_valid_idle", 32'(chk_valid), 32'd0);
    end
    check_state();
    if (acc) begin
      it.a = a; it.b = b; it.op = op; it.res = res; it.z = z;
      sb.push_back(it);
    end
  endtask

  task automatic idle();
    cycle(1'b0, 4'h0, 4'h0, 3'b000, 8'h00, 1'b0);
  endtask

  // Reset and/or clear for one edge with a valid transfer offered alongside
  task automatic apply_sync(input bit do_rst, input bit do_clr);
    @(negedge clk);
    in_valid = 1'b1; operand_a = 4'h1; operand_b = 4'h2; operation = 3'b000;
    dut_result = 8'h03; dut_zero = 1'b0;
    if (do_rst) rst_n = 1'b0;
    if (do_clr) clear = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_eq("sync_chk_valid", 32'(chk_valid), 32'd0);
    check_eq("sync_chk_fail", 32'(chk_fail), 32'd0);
    check_state();
  endtask

  initial begin
    model_reset();
    phase = "reset";
    apply_sync(1'b1, 1'b0);

    phase = "t1_add";
    cycle(1'b1, 4'hD, 4'hA, 3'b000, 8'h17, 1'b0);
    phase = "t2_mul_sub";
    cycle(1'b1, 4'hD, 4'hA, 3'b100, 8'h82, 1'b0);
    cycle(1'b1, 4'hD, 4'hA, 3'b001, 8'h03, 1'b0);
    phase = "t4_illegal";
    cycle(1'b1, 4'h3, 4'h4, 3'b110, 8'h55, 1'b1);
    phase = "legal_mix";
    cycle(1'b1, 4'h3, 4'h5, 3'b001, 8'hFE, 1'b0);
    cycle(1'b1, 4'h5, 4'h5, 3'b001, 8'h00, 1'b1);
    cycle(1'b1, 4'hF, 4'hF, 3'b100, 8'hE1, 1'b0);
    cycle(1'b1, 4'hF, 4'hF, 3'b000, 8'h1E, 1'b0);
    cycle(1'b1, 4'h9, 4'h6, 3'b011, 8'h0F, 1'b0);
    cycle(1'b1, 4'h7, 4'h0, 3'b111, 8'h00, 1'b0);
    idle();

    phase = "t3_fail_halt";
    cycle(1'b1, 4'h5, 4'hA, 3'b010, 8'h00, 1'b0);
    cycle(1'b1, 4'h1, 4'h1, 3'b000, 8'h02, 1'b0);
    idle();
    cycle(1'b1, 4'h2, 4'h2, 3'b000, 8'h04, 1'b0);
    idle();

    phase = "clear_halted";
    apply_sync(1'b0, 1'b1);
    phase = "cap_first_only";
    cycle(1'b1, 4'h3, 4'h4, 3'b011, 8'h06, 1'b0);
    cycle(1'b1, 4'h2, 4'h2, 3'b000, 8'h05, 1'b0);
    idle();

    phase = "t6_clear_busy";
    apply_sync(1'b0, 1'b1);
    cycle(1'b1, 4'h1, 4'h1, 3'b000, 8'h02, 1'b1);
    cycle(1'b1, 4'h4, 4'h3, 3'b000, 8'h07, 1'b0);
    apply_sync(1'b0, 1'b1);

    phase = "t5_saturate";
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 4'(i % 16), 4'h1, 3'b000, 8'((i % 16) + 1), 1'b0);
    end
    idle();

    phase = "t6_reset_mid";
    cycle(1'b1, 4'h2, 4'h3, 3'b100, 8'h06, 1'b0);
    cycle(1'b1, 4'h8, 4'h1, 3'b001, 8'h07, 1'b0);
    apply_sync(1'b1, 1'b1);
    cycle(1'b1, 4'hC, 4'h3, 3'b010, 8'h00, 1'b1);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
